// File: rtl/alu_issue_wb.sv
// Operand-fetch / writeback stage around an 8-bit ALU: 32x8 register file,
// N/Z/C status, valid/ready op intake, timed ALU wait, then Rd (and Rd+1) writeback.
//   clk, rst        : clock, asynchronous active-low reset
//   in_*            : decoded op (valid/ready handshake)
//   alu_* out       : registered ALU operands, opcode and carry-in
//   alu_* in        : ALU result and flags
//   sreg_o, done    : {N,Z,C} status and writeback pulse
//   dbg_addr/data   : combinational register-file read port
module alu_issue_wb #(
  parameter int RESULT_LAT = 1,
  parameter int NREGS      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rr,
  input  logic [7:0]  in_imm,
  input  logic        in_use_imm,
  input  logic        in_wide,
  input  logic        in_flag_we,
  output logic [7:0]  alu_rd,
  output logic [7:0]  alu_rr,
  output logic        alu_ci,
  output logic [7:0]  alu_opcode,
  input  logic [15:0] alu_data_o,
  input  logic        alu_co,
  input  logic        alu_zo,
  input  logic        alu_no,
  output logic [2:0]  sreg_o,
  output logic        done,
  input  logic [4:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  localparam int CW = (RESULT_LAT < 2) ? 1 : $clog2(RESULT_LAT + 1);
  localparam logic [5:0] NR = 6'(NREGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_accept;

  logic [7:0]    r_regs [NREGS];
  logic          r_n;
  logic          r_z;
  logic          r_c;

  logic [CW-1:0] r_cnt;
  logic [4:0]    r_rd;
  logic          r_wide;
  logic          r_flag_we;
  logic [15:0]   r_res;
  logic          r_res_n;
  logic          r_res_z;
  logic          r_res_c;

  logic [7:0]    w_rd_val;
  logic [7:0]    w_rr_val;
  logic [4:0]    w_rd_hi;

  always_comb begin
    w_rd_val = 8'h00;
    w_rr_val = 8'h00;
    dbg_data = 8'h00;
    if ({1'b0, in_rd} < NR)
      w_rd_val = r_regs[in_rd];
    if ({1'b0, in_rr} < NR)
      w_rr_val = r_regs[in_rr];
    if ({1'b0, dbg_addr} < NR)
      dbg_data = r_regs[dbg_addr];
  end

  // 5-bit add gives the R31 -> R0 wrap for wide results
  assign w_rd_hi = r_rd + 5'd1;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = EXEC;
        end
      end
      EXEC: begin
        if (r_cnt == CW'(1))
          w_next = WB;
      end
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign in_ready = (r_state == IDLE);
  assign done     = (r_state == WB);
  assign sreg_o   = {r_n, r_z, r_c};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_rd     <= 8'h00;
      alu_rr     <= 8'h00;
      alu_ci     <= 1'b0;
      alu_opcode <= 8'h00;
      r_cnt      <= '0;
      r_rd       <= 5'd0;
      r_wide     <= 1'b0;
      r_flag_we  <= 1'b0;
      r_res      <= 16'h0000;
      r_res_n    <= 1'b0;
      r_res_z    <= 1'b0;
      r_res_c    <= 1'b0;
    end else begin
      if (w_accept) begin
        alu_rd     <= w_rd_val;
        alu_rr     <= in_use_imm ? in_imm : w_rr_val;
        alu_ci     <= r_c;
        alu_opcode <= in_opcode;
        r_cnt      <= CW'(RESULT_LAT);
        r_rd       <= in_rd;
        r_wide     <= in_wide;
        r_flag_we  <= in_flag_we;
      end else if (r_state == EXEC) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_res   <= alu_data_o;
          r_res_n <= alu_no;
          r_res_z <= alu_zo;
          r_res_c <= alu_co;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= 8'h00;
      r_n <= 1'b0;
      r_z <= 1'b0;
      r_c <= 1'b0;
    end else if (r_state == WB) begin
      if ({1'b0, r_rd} < NR)
        r_regs[r_rd] <= r_res[7:0];
      if (r_wide && ({1'b0, w_rd_hi} < NR))
        r_regs[w_rd_hi] <= r_res[15:8];
      if (r_flag_we) begin
        r_n <= r_res_n;
        r_z <= r_res_z;
        r_c <= r_res_c;
      end
    end
  end

endmodule
